// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and sizes for the data-memory store buffer
package mem_pkg;

    localparam int SB_DEPTH = 4;
    localparam int WORD_W   = 32;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);

    typedef logic [SB_PTR_W-1:0] sb_ptr_t;

    typedef struct packed {
        logic [29:0]       addr;
        logic [WORD_W-1:0] data;
        logic [WORD_W-1:0] pc;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - youngest-match store-to-load forwarding search
module sb_fwd_match
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t          entries [DEPTH],
    input  logic [DEPTH-1:0]   valid,
    input  logic [PTR_W-1:0]   tail,
    input  logic [29:0]        ld_word,
    output logic               hit,
    output logic [WORD_W-1:0]  hit_data
);

    // Walk backward from the newest entry; the first match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && valid[tail - PTR_W'(i + 1)] &&
                entries[tail - PTR_W'(i + 1)].addr == ld_word) begin
                hit      = 1'b1;
                hit_data = entries[tail - PTR_W'(i + 1)].data;
            end
        end
    end

endmodule

// File: rtl/dm_store_buffer.sv
// rtl/dm_store_buffer.sv - write-posting store FIFO with load forwarding and drain arbitration
module dm_store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic [31:0]       st_pc,
    output logic              st_stall,
    input  logic              ld_valid,
    input  logic [31:0]       ld_addr,
    output logic [31:0]       ld_data,
    input  logic [31:0]       dm_do,
    input  logic              drain_en,
    input  logic              sync_req,
    output logic              sync_stall,
    output logic              empty,
    output logic [PTR_W:0]    count,
    output logic              dm_write,
    output logic [31:0]       dm_a,
    output logic [31:0]       dm_di,
    output logic [31:0]       dm_pc
);

    sb_entry_t          entries_q [DEPTH];
    sb_entry_t          entries_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [DEPTH-1:0]   valid;
    logic               pop, push, full;
    logic               fwd_hit;
    logic [WORD_W-1:0]  fwd_data;
    logic               unused_st_low;

    assign unused_st_low = ^st_addr[1:0];

    // Holding reset low forces the idle view even while old state is still in the flops.
    assign full       = (count_q == (PTR_W+1)'(DEPTH));
    assign empty      = !reset || (count_q == '0);
    assign pop        = !empty && drain_en && !ld_valid;
    assign st_stall   = reset && st_valid && full && !pop;
    assign push       = st_valid && !st_stall;
    assign sync_stall = sync_req && !empty;
    assign count      = count_q;

    always_comb begin
        valid = '0;
        for (int j = 0; j < DEPTH; j++) begin
            valid[j] = ({1'b0, PTR_W'(PTR_W'(j) - head_q)} < count_q);
        end
    end

    sb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
        .entries  (entries_q),
        .valid    (valid),
        .tail     (tail_q),
        .ld_word  (ld_addr[31:2]),
        .hit      (fwd_hit),
        .hit_data (fwd_data)
    );

    assign ld_data = fwd_hit ? fwd_data : dm_do;

    always_comb begin
        dm_write = 1'b0;
        dm_a     = ld_addr;
        dm_di    = '0;
        dm_pc    = '0;
        if (pop) begin
            dm_write = 1'b1;
            dm_a     = {entries_q[head_q].addr, 2'b00};
            dm_di    = entries_q[head_q].data;
            dm_pc    = entries_q[head_q].pc;
        end
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (push) begin
            entries_d[tail_q] = '{addr: st_addr[31:2], data: st_data, pc: st_pc};
            tail_d            = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payloads are only meaningful under the valid window, so they skip reset.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb/tb_dm_store_buffer.sv - scoreboard bench for dm_store_buffer against a queue reference model
module tb_dm_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, ld_valid, drain_en, sync_req;
    logic [31:0] st_addr, st_data, st_pc, ld_addr, dm_do;
    logic        st_stall, sync_stall, empty, dm_write;
    logic [2:0]  count;
    logic [31:0] ld_data, dm_a, dm_di, dm_pc;

    always #5 clk = ~clk;

    dm_store_buffer dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
        .st_stall(st_stall),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .dm_do(dm_do),
        .drain_en(drain_en), .sync_req(sync_req), .sync_stall(sync_stall),
        .empty(empty), .count(count),
        .dm_write(dm_write), .dm_a(dm_a), .dm_di(dm_di), .dm_pc(dm_pc)
    );

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    ent_t        exp_wr[$];
    logic [31:0] exp_ld[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic        mon_en = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] la, logic [31:0] dd);
        for (int k = mq.size() - 1; k >= 0; k--) begin
            if (mq[k].a == la[31:2]) return mq[k].d;
        end
        return dd;
    endfunction

    // Monitor: consumes expectations whenever the DUT presents a write or a load.
    always @(negedge clk) begin
        if (mon_en) begin
            assert (!(st_valid && ld_valid)) else $error("st_valid and ld_valid both high");
            if (dm_write) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: dm_a=0x%08h dm_di=0x%08h with none expected", dm_a, dm_di);
                end else begin
                    ent_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", dm_a, {e.a, 2'b00});
                    check("wr_data", dm_di, e.d);
                    check("wr_pc", dm_pc, e.pc);
                end
            end
            if (ld_valid) begin
                if (exp_ld.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: ld_data=0x%08h with none expected", ld_data);
                end else begin
                    check("ld_data", ld_data, exp_ld.pop_front());
                end
            end
        end
    end

    task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la, input logic [31:0] dd,
                         input logic de, input logic sr);
        int   n;
        logic mpop, mstall, mpush;
        st_valid = sv; st_addr = sa; st_data = sd; st_pc = pc_ctr;
        ld_valid = lv; ld_addr = la; dm_do = dd; drain_en = de; sync_req = sr;
        n      = mq.size();
        mpop   = (n > 0) && de && !lv;
        mstall = sv && (n == DEPTH) && !mpop;
        mpush  = sv && !mstall;
        if (lv)   exp_ld.push_back(ref_load(la, dd));
        if (mpop) exp_wr.push_back(mq[0]);
        @(negedge clk);
        check("count", {29'd0, count}, n);
        check("empty", {31'd0, empty}, {31'd0, n == 0});
        check("st_stall", {31'd0, st_stall}, {31'd0, mstall});
        check("sync_stall", {31'd0, sync_stall}, {31'd0, sr && n > 0});
        check("dm_write", {31'd0, dm_write}, {31'd0, mpop});
        if (!mpop) begin
            check("dm_a_idle", dm_a, la);
            check("dm_di_idle", dm_di, 32'd0);
        end
        @(posedge clk);
        if (mpop) void'(mq.pop_front());
        if (mpush) begin
            mq.push_back('{a: sa[31:2], d: sd, pc: pc_ctr});
            pc_ctr += 4;
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        st_valid = 1'b1; st_addr = 32'h40; st_data = 32'hDEAD_0000; st_pc = 32'h0;
        ld_valid = 1'b0; ld_addr = 32'h0; dm_do = 32'h0; drain_en = 1'b1; sync_req = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (mon_en) begin
                check("rst_dm_write", {31'd0, dm_write}, 32'd0);
                check("rst_empty", {31'd0, empty}, 32'd1);
                check("rst_st_stall", {31'd0, st_stall}, 32'd0);
                check("rst_sync_stall", {31'd0, sync_stall}, 32'd0);
            end
            @(posedge clk);
        end
        #1;
        reset = 1'b1;
        st_valid = 1'b0; drain_en = 1'b0; sync_req = 1'b0;
        mq.delete();
    endtask

    initial begin
        logic [31:0] ra, rd, rla, rdd;
        logic        rsv, rlv, rde;
        do_reset(2);
        mon_en = 1'b1;

        // Single store, forward, drain.
        cycle(1, 32'h10, 32'hAAAA_0001, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h10, 32'h0, 0, 0);
        cycle(0, 0, 0, 0, 32'h88, 0, 1, 0);
        cycle(0, 0, 0, 0, 32'h8C, 0, 1, 0);

        // Youngest match among three stores to one word.
        for (int i = 1; i <= 3; i++) cycle(1, 32'h20, i, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'h22, 32'h5555_5555, 0, 0);
        cycle(0, 0, 0, 1, 32'h24, 32'h1234_5678, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // Full, held stall, then concurrent pop and push.
        for (int i = 0; i < 4; i++) cycle(1, 32'h100 + 4 * i, 32'hB000_0000 + i, 0, 0, 0, 0, 0);
        cycle(1, 32'h200, 32'hC0DE_0005, 0, 0, 0, 0, 0);
        cycle(1, 32'h200, 32'hC0DE_0005, 0, 0, 0, 0, 0);
        cycle(1, 32'h200, 32'hC0DE_0005, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // Loads own the address port.
        cycle(1, 32'h300, 32'h0000_0300, 0, 0, 0, 0, 0);
        cycle(1, 32'h304, 32'h0000_0304, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 32'h400 + 4 * i, 32'hFEED_0000 + i, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // Sync while draining.
        for (int i = 0; i < 3; i++) cycle(1, 32'h500 + 4 * i, 32'h5000 + i, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, 1);

        // Reset discards queued stores.
        cycle(1, 32'h600, 32'h6666_0000, 0, 0, 0, 0, 0);
        cycle(1, 32'h604, 32'h6666_0004, 0, 0, 0, 0, 0);
        do_reset(1);
        cycle(0, 0, 0, 1, 32'h600, 32'h0BAD_F00D, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // Random traffic over a small address pool to provoke aliasing.
        for (int n = 0; n < 500; n++) begin
            rsv = ($urandom_range(0, 2) == 0);
            rlv = !rsv && ($urandom_range(0, 2) == 0);
            rde = (n < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ra  = 32'h800 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
            rla = 32'h800 + 4 * $urandom_range(0, 9) + $urandom_range(0, 3);
            rd  = $urandom;
            rdd = $urandom;
            cycle(rsv, ra, rd, rlv, rla, rdd, rde, $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);

        @(negedge clk);
        check("wr_left", exp_wr.size(), 32'd0);
        check("ld_left", exp_ld.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Write-posting buffer between the MEM-stage store path and the data memory.
- Accepts word stores from the pipeline, queues them in a FIFO of DEPTH entries, and drains one entry per cycle to the data memory's single write port.
- Forwards buffered data to loads so the pipeline sees program-order memory.
- Arbitrates the memory's shared address port between loads and drains, and provides a sync (drain-until-empty) request for ordering points.

Parameters:
DEPTH, 4, number of store entries (power of two, >= 2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
st_valid  in  1  MEM stage issues a word store this cycle
st_addr  in  32  store byte address (bits [1:0] ignored)
st_data  in  32  store data
st_pc  in  32  PC of the store instruction
st_stall  out  1  store not accepted; upstream holds st_* and stalls
ld_valid  in  1  MEM stage issues a word load this cycle
ld_addr  in  32  load byte address
ld_data  out  32  load result, combinational
dm_do  in  32  data memory read data
drain_en  in  1  memory write port available this cycle
sync_req  in  1  ordering point; buffer must empty
sync_stall  out  1  sync_req high and buffer not empty
empty  out  1  no valid entries
count  out  PTR_W+1  number of valid entries
dm_write  out  1  write strobe to data memory
dm_a  out  32  data memory address (shared read/write)
dm_di  out  32  data memory write data
dm_pc  out  32  PC of the draining store

Behaviour:
- Storage: circular FIFO, DEPTH entries {addr[31:2], data, pc}; head/tail pointers PTR_W bits; count register PTR_W+1 bits.
- Reset (reset==0 at posedge): head=tail=0, count=0. During and after reset: dm_write=0, st_stall=0, empty=1, sync_stall=0. Entry payloads are not cleared.
- Reset mid-operation discards all queued stores; none are written to memory.
- pop = !empty && drain_en && !ld_valid. Loads own dm_a in that cycle.
- Drain outputs when pop=1:
  - dm_write=1
  - dm_a={head.addr,2'b00}
  - dm_di=head.data, dm_pc=head.pc
  - head advances at the posedge.
- When pop=0: dm_write=0, dm_a=ld_addr, dm_di=0, dm_pc=0.
- push = st_valid && !st_stall. Entry is written at tail on the posedge; tail advances.
- st_stall = st_valid && (count==DEPTH) && !pop.
  - Full with simultaneous pop: the push is accepted and count stays at DEPTH.
- count_next = count + push - pop. Pointers wrap modulo DEPTH.
- Forwarding:
  - Compare ld_addr[31:2] with every valid entry's addr.
  - If any match, ld_data = data of the youngest matching entry (nearest to tail-1, searching backward).
  - Otherwise ld_data = dm_do.
- The head entry is valid for matching even in a cycle it would pop (pop is 0 whenever ld_valid=1 anyway).
- A store pushed at edge N is visible to loads from cycle N+1. Draining never changes a load result, because memory then holds the same value.
- st_valid and ld_valid are never high together: one MEM-stage instruction per cycle. The bench asserts this.
- sync_stall = sync_req && !empty. Draining continues normally during sync.
- drain_en=0 holds the contents indefinitely. Loads still forward.
- Every output except count is combinational from registers and inputs. Latency: store-to-memory is at least 1 cycle after acceptance.

Decomposition:
- Shared package mem_pkg:
  - SB_DEPTH, WORD_W=32
  - typedef sb_entry_t {addr[29:0], data[31:0], pc[31:0]}
  - typedef sb_ptr_t
- One sub-module, sb_fwd_match: inputs are the entry array, valid vector, tail pointer and ld_addr. Outputs are hit and youngest-match data. This is pure combinational priority logic.

Test Plan:
- Reset then release; push st_addr=0x10 data=0xAAAA0001 with drain_en=0 -> count=1, ld_addr=0x10 gives ld_data=0xAAAA0001 with dm_do=0; set drain_en=1 -> one cycle dm_write=1, dm_a=0x10, dm_di=0xAAAA0001, then empty=1.
- drain_en=0; push 0x20 with 1, 2, 3 -> load 0x20 returns 3 (youngest match); load 0x24 returns dm_do.
- drain_en=0; push 4 stores -> count=4; 5th store -> st_stall=1, held; raise drain_en -> same cycle st_stall=0, count stays 4, head written to memory.
- Buffer holds 2 entries, drain_en=1, ld_valid=1 for 3 cycles -> dm_write=0, dm_a=ld_addr throughout; after ld_valid drops -> drains on 2 consecutive cycles.
- 3 entries queued, sync_req=1 -> sync_stall=1 for 3 cycles, 0 in the cycle count reaches 0.
- 2 entries queued, assert reset low for 1 cycle -> count=0, empty=1, no dm_write afterwards; a load to a queued address returns dm_do.
